keccak_round_ctrl: RTL and testbench

- Sequencer for one Keccak-f[1600] permutation.
- Accepts a permutation request over a valid/ready handshake and drives the 5-bit round-constant address into the Keccak constant ROM.
- Issues per-cycle round enables to the round datapath, holding UR unrolled rounds per cycle, and signals completion over a valid/ready handshake.
- Sits between the SHAKE/SHA3 absorb/squeeze controller (upstream) and the round-constant ROM plus round logic (downstream).

---
 rtl/keccak_round_ctrl.sv | 109 ++++++++++
 tb/tb_keccak_round_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for one Keccak-f[1600] permutation: accepts a request, steps the
// round-constant address UR rounds per cycle, then holds the result until consumed.
module keccak_round_ctrl #(
   parameter int UR    = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             load_en,
   output logic [4:0]       rc_addr,
   output logic             round_en,
   output logic             last_round,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] perm_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam logic [4:0]       RC_STEP = 5'(UR);
   localparam logic [4:0]       RC_LAST = 5'(24 - UR);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   generate
      if (UR != 1 && UR != 2 && UR != 3 && UR != 4 &&
          UR != 6 && UR != 8 && UR != 12 && UR != 24) begin : g_bad_ur
         $error("keccak_round_ctrl: UR must divide 24");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [4:0]       rc_addr_q, rc_addr_d;
   logic [CNT_W-1:0] perm_cnt_q, perm_cnt_d;
   logic             is_idle, is_round, is_hold, at_last;

   always_comb begin
      is_idle  = (state_q == IDLE);
      is_round = (state_q == ROUND);
      is_hold  = (state_q == HOLD);
      at_last  = (rc_addr_q == RC_LAST);
   end

   // Handshake outputs are masked during reset so nothing downstream acts on stale state.
   always_comb begin
      in_ready   = ~rst & is_idle;
      load_en    = ~rst & is_idle & in_valid;
      round_en   = ~rst & is_round;
      last_round = ~rst & is_round & at_last;
      out_valid  = ~rst & is_hold;
      busy       = is_round | is_hold;
      rc_addr    = rc_addr_q;
      perm_cnt   = perm_cnt_q;
   end

   always_comb begin
      state_d    = state_q;
      rc_addr_d  = rc_addr_q;
      perm_cnt_d = perm_cnt_q;
      unique case (state_q)
         IDLE: begin
            rc_addr_d = '0;
            if (in_valid) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (at_last) begin
               state_d   = HOLD;
               rc_addr_d = '0;
            end else begin
               rc_addr_d = rc_addr_q + RC_STEP;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               if (perm_cnt_q != CNT_MAX) begin
                  perm_cnt_d = perm_cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            rc_addr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rc_addr_q  <= '0;
         perm_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rc_addr_q  <= rc_addr_d;
         perm_cnt_q <= perm_cnt_d;
      end
   end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: four instances (UR=1/4/24 and a 2-bit counter) driven by
// scenario tasks and checked against an expected round schedule derived from UR.
module tb_keccak_round_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst        [4];
   logic        in_valid   [4];
   logic        out_ready  [4];
   logic        in_ready   [4];
   logic        load_en    [4];
   logic        round_en   [4];
   logic        last_round [4];
   logic        out_valid  [4];
   logic        busy       [4];
   logic [4:0]  rc_addr    [4];
   logic [15:0] cnt16      [3];
   logic [1:0]  cnt2;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int exp_cnt    [4];
   int accept_cyc [4];

   always @(posedge clk) cyc <= cyc + 1;

   keccak_round_ctrl #(.UR(1), .CNT_W(16)) dut_ur1 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .load_en(load_en[0]), .rc_addr(rc_addr[0]), .round_en(round_en[0]),
      .last_round(last_round[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .busy(busy[0]), .perm_cnt(cnt16[0]));

   keccak_round_ctrl #(.UR(4), .CNT_W(16)) dut_ur4 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .load_en(load_en[1]), .rc_addr(rc_addr[1]), .round_en(round_en[1]),
      .last_round(last_round[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .busy(busy[1]), .perm_cnt(cnt16[1]));

   keccak_round_ctrl #(.UR(24), .CNT_W(16)) dut_ur24 (
      .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .load_en(load_en[2]), .rc_addr(rc_addr[2]), .round_en(round_en[2]),
      .last_round(last_round[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .busy(busy[2]), .perm_cnt(cnt16[2]));

   keccak_round_ctrl #(.UR(1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .load_en(load_en[3]), .rc_addr(rc_addr[3]), .round_en(round_en[3]),
      .last_round(last_round[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
      .busy(busy[3]), .perm_cnt(cnt2));

   // Upstream rule: a request that is not accepted must stay asserted.
   for (genvar g = 0; g < 4; g++) begin : g_hold_chk
      assert property (@(posedge clk) disable iff (rst[g])
                       (in_valid[g] && !in_ready[g]) |=> in_valid[g])
         else $error("[TB] upstream dropped in_valid before accept on instance %0d", g);
   end

   function automatic int ur_of(input int k);
      case (k)
         1:       return 4;
         2:       return 24;
         default: return 1;
      endcase
   endfunction

   function automatic int cnt_max(input int k);
      return (k == 3) ? 3 : 65535;
   endfunction

   function automatic int cnt_of(input int k);
      if (k == 3) return int'(cnt2);
      return int'(cnt16[k]);
   endfunction

   // {in_ready, load_en, round_en, last_round, out_valid, busy}
   function automatic logic [5:0] flags(input int k);
      return {in_ready[k], load_en[k], round_en[k], last_round[k], out_valid[k], busy[k]};
   endfunction

   // Entered and left at a negedge while the instance is idle. keep=1 leaves a new
   // request pending from the first round cycle onward (back-to-back traffic).
   task automatic do_perm(input int k, input int hold, input bit keep);
      int n;
      n = 24 / ur_of(k);
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b0;
      #1;
      checks++;
      if (flags(k) !== 6'b110000)
         $display("[TB] FAIL accept_flags k=%0d got %b exp 110000", k, flags(k));
      else passes++;
      accept_cyc[k] = cyc;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (flags(k) !== ((i == n - 1) ? 6'b001101 : 6'b001001) || rc_addr[k] !== 5'(i * ur_of(k)))
            $display("[TB] FAIL round k=%0d i=%0d got flags %b addr %0d exp addr %0d last %0d",
                     k, i, flags(k), rc_addr[k], i * ur_of(k), (i == n - 1));
         else passes++;
         in_valid[k] = keep;
      end
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         checks++;
         if (flags(k) !== 6'b000011 || rc_addr[k] !== 5'd0)
            $display("[TB] FAIL hold k=%0d h=%0d got flags %b addr %0d exp flags 000011 addr 0",
                     k, h, flags(k), rc_addr[k]);
         else passes++;
         out_ready[k] = (h == hold);
      end
      @(negedge clk);
      out_ready[k] = 1'b0;
      if (exp_cnt[k] < cnt_max(k)) exp_cnt[k]++;
      checks++;
      if (flags(k) !== (keep ? 6'b110000 : 6'b100000) || cnt_of(k) !== exp_cnt[k])
         $display("[TB] FAIL done k=%0d got flags %b cnt %0d exp cnt %0d",
                  k, flags(k), cnt_of(k), exp_cnt[k]);
      else passes++;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0; exp_cnt[k] = 0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (flags(k) !== 6'b000000)
            $display("[TB] FAIL in_reset k=%0d got %b exp 000000", k, flags(k));
         else passes++;
         rst[k] = 1'b0;
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (flags(k) !== 6'b100000 || rc_addr[k] !== 5'd0 || cnt_of(k) !== 0)
               $display("[TB] FAIL idle_after_reset k=%0d c=%0d got flags %b addr %0d cnt %0d exp 100000/0/0",
                        k, c, flags(k), rc_addr[k], cnt_of(k));
            else passes++;
         end
      end
   endtask

   task automatic test_ur1_single();
      do_perm(0, 0, 1'b0);
   endtask

   task automatic test_ur4_ur24();
      do_perm(1, 0, 1'b0);
      do_perm(2, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      do_perm(0, 5, 1'b1);
      do_perm(0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      in_valid[0] = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         in_valid[0] = 1'b0;
         checks++;
         if (round_en[0] !== 1'b1 || rc_addr[0] !== 5'(i))
            $display("[TB] FAIL pre_reset_round i=%0d got en %b addr %0d exp 1/%0d",
                     i, round_en[0], rc_addr[0], i);
         else passes++;
      end
      rst[0] = 1'b1;
      #1;
      checks++;
      if (flags(0) !== 6'b000001)
         $display("[TB] FAIL rst_masks_outputs got %b exp 000001", flags(0));
      else passes++;
      @(negedge clk);
      checks++;
      if (flags(0) !== 6'b000000 || rc_addr[0] !== 5'd0 || cnt_of(0) !== 0)
         $display("[TB] FAIL after_mid_reset got flags %b addr %0d cnt %0d exp 000000/0/0",
                  flags(0), rc_addr[0], cnt_of(0));
      else passes++;
      rst[0] = 1'b0;
      exp_cnt[0] = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         checks++;
         if (flags(0) !== 6'b100000)
            $display("[TB] FAIL no_out_after_reset c=%0d got %b exp 100000", c, flags(0));
         else passes++;
      end
   endtask

   task automatic test_saturation();
      int prev;
      for (int p = 0; p < 5; p++) begin
         do_perm(3, 0, p < 4);
         if (p > 0) begin
            checks++;
            if (accept_cyc[3] - prev !== 26)
               $display("[TB] FAIL req_period p=%0d got %0d exp 26", p, accept_cyc[3] - prev);
            else passes++;
         end
         prev = accept_cyc[3];
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         int k, gap, hold;
         k    = $urandom_range(0, 2);
         gap  = $urandom_range(0, 3);
         hold = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         do_perm(k, hold, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_ur1_single();
      test_ur4_ur24();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
